instr_fetch_unit: RTL and testbench

//   Fetch stage directly downstream of program_counter: takes the current pc, issues one

---
 rtl/fetch_pkg.sv | 26 ++
 rtl/fetch_fifo.sv | 67 ++++++
 rtl/instr_fetch_unit.sv | 121 ++++++++++++
 tb/tb_instr_fetch_unit.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// ============================================================================
// Module : fetch_pkg
// Shared types and constants for the instruction fetch stage.
// Rev    : 1.0
// ============================================================================
`default_nettype none

package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_RSP = 2'd2,
        FAULT    = 2'd3
    } fetch_state_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

    localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
// ============================================================================
// Module : fetch_fifo
// Small {pc, instr} FIFO; flush has priority over push and pop.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            push_i,
    input  fetch_entry_t    entry_i,
    input  logic            pop_i,
    input  logic            flush_i,
    output logic [AW:0]     count_o,
    output logic            empty_o,
    output fetch_entry_t    head_o
);

    fetch_entry_t       mem_q [DEPTH];
    logic [AW-1:0]      wr_ptr_q;
    logic [AW-1:0]      rd_ptr_q;
    logic [AW:0]        count_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push_i && !pop_i) begin
                count_q <= count_q + 1'b1;
            end else if (pop_i && !push_i) begin
                count_q <= count_q - 1'b1;
            end
        end
    end

    // Storage needs no reset; the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) begin
            mem_q[wr_ptr_q] <= entry_i;
        end
    end

    assign count_o = count_q;
    assign empty_o = (count_q == '0);
    assign head_o  = mem_q[rd_ptr_q];

endmodule

`default_nettype wire

// File: rtl/instr_fetch_unit.sv
// ============================================================================
// Module : instr_fetch_unit
// Fetch stage: one outstanding imem read, {pc, instr} FIFO toward decode.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int          DEPTH     = 2,
    parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc,
    input  logic        redirect,
    output logic        imem_req_valid,
    output logic [31:0] imem_req_addr,
    input  logic        imem_req_ready,
    input  logic        imem_rsp_valid,
    input  logic [31:0] imem_rsp_data,
    output logic        fetch_stall,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    input  logic        if_ready,
    output logic        fetch_fault
);

    localparam int AW = $clog2(DEPTH);

    fetch_state_t   state_q;
    logic [31:0]    req_addr_q;
    logic           drop_q;

    logic [AW:0]    fifo_count;
    logic           fifo_empty;
    fetch_entry_t   fifo_head;
    fetch_entry_t   push_entry;
    logic           push;
    logic           pop;
    logic           has_space;

    assign has_space  = (fifo_count < (AW+1)'(DEPTH));
    assign push       = (state_q == WAIT_RSP) && imem_rsp_valid && !drop_q && !redirect;
    assign pop        = if_valid && if_ready;
    assign push_entry = '{pc: req_addr_q, instr: imem_rsp_data};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            req_addr_q <= '0;
            drop_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (redirect) begin
                        state_q <= IDLE;
                    end else if (pc[1:0] != 2'b00) begin
                        state_q <= FAULT;
                    end else if (has_space) begin
                        state_q    <= REQ;
                        req_addr_q <= pc;
                    end
                end
                REQ: begin
                    if (redirect) begin
                        drop_q <= 1'b1;
                    end
                    if (imem_req_ready) begin
                        state_q <= WAIT_RSP;
                    end
                end
                WAIT_RSP: begin
                    if (imem_rsp_valid) begin
                        drop_q  <= 1'b0;
                        state_q <= IDLE;
                    end else if (redirect) begin
                        drop_q <= 1'b1;
                    end
                end
                FAULT: begin
                    if (redirect) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    fetch_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .entry_i (push_entry),
        .pop_i   (pop),
        .flush_i (redirect),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .head_o  (fifo_head)
    );

    // PC advances exactly once, in the cycle the memory accepts the request.
    assign fetch_stall    = !((state_q == REQ) && imem_req_ready);
    assign imem_req_valid = (state_q == REQ);
    assign imem_req_addr  = req_addr_q;
    assign fetch_fault    = (state_q == FAULT);

    assign if_valid = !fifo_empty && !redirect;
    assign if_instr = fifo_empty ? NOP_INSTR : fifo_head.instr;
    assign if_pc    = fifo_empty ? 32'h0 : fifo_head.pc;

endmodule

`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
// ============================================================================
// Module : tb_instr_fetch_unit
// Directed self-checking bench for instr_fetch_unit (DEPTH=2).
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_instr_fetch_unit;

    logic        clk;
    logic        rst_n;
    logic [31:0] pc;
    logic        redirect;
    logic        imem_req_valid;
    logic [31:0] imem_req_addr;
    logic        imem_req_ready;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        fetch_stall;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_ready;
    logic        fetch_fault;

    int tests_run;
    int tests_failed;

    localparam logic [31:0] NOP = 32'h0000_0013;
    localparam logic [31:0] D1  = 32'h0050_0093;
    localparam logic [31:0] D2  = 32'h0010_0113;
    localparam logic [31:0] D3  = 32'h0020_8193;
    localparam logic [31:0] D4  = 32'h0031_0213;
    localparam logic [31:0] DX  = 32'hDEAD_BEEF;

    instr_fetch_unit #(
        .DEPTH     (2),
        .NOP_INSTR (NOP)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc             (pc),
        .redirect       (redirect),
        .imem_req_valid (imem_req_valid),
        .imem_req_addr  (imem_req_addr),
        .imem_req_ready (imem_req_ready),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .fetch_stall    (fetch_stall),
        .if_valid       (if_valid),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_ready       (if_ready),
        .fetch_fault    (fetch_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run      = 0;
        tests_failed   = 0;
        rst_n          = 1'b0;
        pc             = 32'h0;
        redirect       = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = 32'h0;
        if_ready       = 1'b0;
        cyc();
        cyc();

        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rst_req_addr",  imem_req_addr,           32'h0);
        chk("rst_stall",     {31'b0, fetch_stall},    32'd1);
        chk("rst_if_valid",  {31'b0, if_valid},       32'd0);
        chk("rst_if_instr",  if_instr,                NOP);
        chk("rst_if_pc",     if_pc,                   32'h0);
        chk("rst_fault",     {31'b0, fetch_fault},    32'd0);

        // Linear fetch from pc 0
        rst_n          = 1'b1;
        imem_req_ready = 1'b1;
        cyc();
        chk("lin_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("lin_req_addr",  imem_req_addr,           32'h0);
        chk("lin_stall_acc", {31'b0, fetch_stall},    32'd0);
        cyc();
        pc = 32'h4;
        chk("lin_wait_reqv",  {31'b0, imem_req_valid}, 32'd0);
        chk("lin_wait_stall", {31'b0, fetch_stall},    32'd1);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = D1;
        cyc();
        imem_rsp_valid = 1'b0;
        chk("lin_if_valid", {31'b0, if_valid}, 32'd1);
        chk("lin_if_pc",    if_pc,             32'h0);
        chk("lin_if_instr", if_instr,          D1);
        chk("lin_stall_idle", {31'b0, fetch_stall}, 32'd1);
        cyc();
        chk("lin_req2_addr",  imem_req_addr,           32'h4);
        chk("lin_req2_valid", {31'b0, imem_req_valid}, 32'd1);

        // Backpressure: second entry fills the FIFO
        cyc();
        pc = 32'h8;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = D2;
        cyc();
        imem_rsp_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("bp_no_req", {31'b0, imem_req_valid}, 32'd0);
            chk("bp_stall",  {31'b0, fetch_stall},    32'd1);
        end
        chk("bp_head_pc", if_pc, 32'h0);
        if_ready = 1'b1;
        cyc();
        chk("bp_pop1_pc",    if_pc,    32'h4);
        chk("bp_pop1_instr", if_instr, D2);
        cyc();
        chk("bp_empty",      {31'b0, if_valid},       32'd0);
        chk("bp_empty_nop",  if_instr,                NOP);
        chk("bp_req3_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("bp_req3_addr",  imem_req_addr,           32'h8);
        if_ready = 1'b0;

        // Redirect while waiting for the response
        cyc();
        redirect = 1'b1;
        pc       = 32'h100;
        cyc();
        redirect       = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = DX;
        cyc();
        imem_rsp_valid = 1'b0;
        chk("rd_dropped", {31'b0, if_valid}, 32'd0);
        cyc();
        chk("rd_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("rd_req_addr",  imem_req_addr,           32'h100);
        cyc();
        pc             = 32'h104;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = D3;
        cyc();
        imem_rsp_valid = 1'b0;
        chk("rd_if_pc",    if_pc,    32'h100);
        chk("rd_if_instr", if_instr, D3);

        // Push and pop in the same cycle with one entry held
        cyc();
        chk("pp_req_addr", imem_req_addr, 32'h104);
        cyc();
        pc             = 32'h108;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = D4;
        if_ready       = 1'b1;
        chk("pp_head_before", if_pc, 32'h100);
        cyc();
        imem_rsp_valid = 1'b0;
        chk("pp_valid", {31'b0, if_valid}, 32'd1);
        chk("pp_pc",    if_pc,             32'h104);
        chk("pp_instr", if_instr,          D4);
        cyc();
        chk("pp_count1", {31'b0, if_valid}, 32'd0);
        if_ready = 1'b0;

        // Misaligned pc traps until redirected
        cyc();
        pc             = 32'h10C;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = DX;
        cyc();
        imem_rsp_valid = 1'b0;
        chk("mis_pre_valid", {31'b0, if_valid}, 32'd1);
        redirect = 1'b1;
        pc       = 32'h102;
        cyc();
        redirect = 1'b0;
        chk("mis_flushed", {31'b0, if_valid}, 32'd0);
        cyc();
        chk("mis_fault", {31'b0, fetch_fault}, 32'd1);
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("mis_no_req",  {31'b0, imem_req_valid}, 32'd0);
            chk("mis_held",    {31'b0, fetch_fault},    32'd1);
        end
        redirect = 1'b1;
        pc       = 32'h104;
        cyc();
        redirect = 1'b0;
        chk("mis_cleared", {31'b0, fetch_fault}, 32'd0);
        cyc();
        chk("mis_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("mis_req_addr",  imem_req_addr,           32'h104);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
